// File: rtl/puf_challenge_sequencer_if.sv
// Wrapper/sequencer/oscillator-bank signal bundle for the RO-PUF challenge sequencer.
// slave = the sequencer; master = the pin wrapper plus oscillator/counter banks.
interface puf_challenge_sequencer_if #(
   parameter int NUM_BITS = 8
);
   logic                start;
   logic                abort;
   logic [3:0]          challenge;
   logic [15:0]         count_a;
   logic [15:0]         count_b;
   logic [3:0]          osc_sel;
   logic                osc_en;
   logic                cnt_clr;
   logic                busy;
   logic                done;
   logic [NUM_BITS-1:0] response;
   logic                response_valid;
   logic [NUM_BITS-1:0] unstable_mask;

   modport slave (
      input  start, abort, challenge, count_a, count_b,
      output osc_sel, osc_en, cnt_clr, busy, done, response, response_valid, unstable_mask
   );

   modport master (
      output start, abort, challenge, count_a, count_b,
      input  osc_sel, osc_en, cnt_clr, busy, done, response, response_valid, unstable_mask
   );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// RO-PUF sequencer: per bit select pair, clear counters, run window, settle, compare, shift bit.
// Optional low-margin flagging via PUF_MARGIN_EN; rst_n is synchronous and active-high (1 = reset).
module puf_challenge_sequencer #(
   parameter int NUM_BITS = 8,
   parameter int WINDOW   = 1024,
   parameter int SETTLE   = 4,
   parameter int MARGIN   = 16
) (
   input logic                      clk,
   input logic                      rst_n,
   puf_challenge_sequencer_if.slave bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_SETTLE  = 3'd3;
   localparam logic [2:0] S_COMPARE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]          state;
   logic [3:0]          bit_idx;
   logic [3:0]          chal_q;
   logic [15:0]         timer;
   logic [NUM_BITS-1:0] resp_q;
   logic                bit_val;
   logic                last_bit;

   assign bit_val       = bus.count_a > bus.count_b;
   assign last_bit      = bit_idx == 4'(NUM_BITS - 1);
   assign bus.busy      = state != S_IDLE;
   assign bus.response  = resp_q;

`ifdef PUF_MARGIN_EN
   logic [15:0]         diff;
   logic [NUM_BITS-1:0] mask_q;

   // Larger minus smaller, so the 16-bit result never wraps.
   assign diff              = bit_val ? (bus.count_a - bus.count_b) : (bus.count_b - bus.count_a);
   assign bus.unstable_mask = mask_q;
`else
   assign bus.unstable_mask = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state              <= S_IDLE;
         bit_idx            <= '0;
         chal_q             <= '0;
         timer              <= '0;
         resp_q             <= '0;
         bus.osc_sel        <= '0;
         bus.osc_en         <= 1'b0;
         bus.cnt_clr        <= 1'b0;
         bus.done           <= 1'b0;
         bus.response_valid <= 1'b0;
`ifdef PUF_MARGIN_EN
         mask_q             <= '0;
`endif
      end else begin
         bus.done    <= 1'b0;
         bus.cnt_clr <= 1'b0;
         if (state != S_IDLE && bus.abort) begin
            // Partial results are discarded; response_valid is already 0 here.
            state      <= S_IDLE;
            bus.osc_en <= 1'b0;
            resp_q     <= '0;
`ifdef PUF_MARGIN_EN
            mask_q     <= '0;
`endif
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     chal_q             <= bus.challenge;
                     bit_idx            <= '0;
                     bus.osc_sel        <= bus.challenge;
                     bus.cnt_clr        <= 1'b1;
                     bus.response_valid <= 1'b0;
                     resp_q             <= '0;
`ifdef PUF_MARGIN_EN
                     mask_q             <= '0;
`endif
                     state              <= S_CLEAR;
                  end
               end
               S_CLEAR: begin
                  timer      <= 16'(WINDOW - 1);
                  bus.osc_en <= 1'b1;
                  state      <= S_RUN;
               end
               S_RUN: begin
                  if (timer == 16'd0) begin
                     timer      <= 16'(SETTLE - 1);
                     bus.osc_en <= 1'b0;
                     state      <= S_SETTLE;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
               S_SETTLE: begin
                  if (timer == 16'd0) begin
                     state <= S_COMPARE;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
               S_COMPARE: begin
                  for (int i = 0; i < NUM_BITS; i++) begin
                     if (bit_idx == i[3:0]) begin
                        resp_q[i] <= bit_val;
`ifdef PUF_MARGIN_EN
                        mask_q[i] <= diff < 16'(MARGIN);
`endif
                     end
                  end
                  if (last_bit) begin
                     state <= S_DONE;
                  end else begin
                     bit_idx     <= bit_idx + 4'd1;
                     // 4-bit add wraps the select past oscillator 15 back to 0.
                     bus.osc_sel <= chal_q + bit_idx + 4'd1;
                     bus.cnt_clr <= 1'b1;
                     state       <= S_CLEAR;
                  end
               end
               S_DONE: begin
                  bus.done           <= 1'b1;
                  bus.response_valid <= 1'b1;
                  state              <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule
